// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - round-robin shared PISO shift register scheduler for two requesters
module shift_sched #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic         sout,
  output logic         sout_en,
  input  logic         ser_ready,
  output logic         last,
  output logic         owner,
  output logic         busy
);

  localparam int BW = $clog2(W);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  sr, sr_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          ptr, ptr_n;       // 0 favours req0, 1 favours req1
  logic          owner_n;
  logic          ack0_n, ack1_n;
  logic          grant;

  // state and datapath registers; reset clears everything, pointer back to req0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      ptr   <= 1'b0;
      owner <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      bcnt  <= bcnt_n;
      gcnt  <= gcnt_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      ack0  <= ack0_n;
      ack1  <= ack1_n;
    end
  end

  // next-state: arbitrate in IDLE, shift under ser_ready, then count out the gap
  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    ptr_n   = ptr;
    owner_n = owner;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    // a lone request wins outright; the pointer only breaks ties
    grant   = (req0 && req1) ? ptr : req1;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          sr_n    = grant ? data1 : data0;
          owner_n = grant;
          ack0_n  = ~grant;
          ack1_n  = grant;
          bcnt_n  = BIT_LOAD;
          ptr_n   = ~grant;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          sr_n = {sr[W-2:0], 1'b0};
          if (bcnt == '0) begin
            gcnt_n  = GAP_LOAD;
            state_n = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bcnt_n = bcnt - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gcnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // serial outputs are decoded from state so reset clears them at once
  assign sout_en = (state == ST_SHIFT);
  assign sout    = sout_en & sr[W-1];
  assign last    = sout_en & (bcnt == '0);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed scoreboard bench for shift_sched
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, ser_ready;
  logic [3:0] data0, data1;
  logic       ack0, ack1, sout, sout_en, last, owner, busy;

  logic       g0_req0, g0_req1, g0_ready;
  logic [3:0] g0_data0, g0_data1;
  logic       g0_ack0, g0_ack1, g0_sout, g0_sout_en, g0_last, g0_owner, g0_busy;

  int total = 0;
  int bad   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int g0_ack_cnt = 0;
  int snap;
  logic [2:0] q[$];
  logic [2:0] q_g0[$];

  always #5 clk = ~clk;

  shift_sched #(.W(4), .GAP(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .sout(sout), .sout_en(sout_en),
    .ser_ready(ser_ready), .last(last), .owner(owner), .busy(busy)
  );

  shift_sched #(.W(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .req0(g0_req0), .data0(g0_data0), .req1(g0_req1), .data1(g0_data1),
    .ack0(g0_ack0), .ack1(g0_ack1), .sout(g0_sout), .sout_en(g0_sout_en),
    .ser_ready(g0_ready), .last(g0_last), .owner(g0_owner), .busy(g0_busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected bits of one frame, MSB first, as {owner, bit, last}
  task automatic push_frame(input logic own, input logic [3:0] d, input bit to_g0);
    for (int i = 3; i >= 0; i--) begin
      if (to_g0) q_g0.push_back({own, d[i], (i == 0)});
      else       q.push_back({own, d[i], (i == 0)});
    end
  endtask

  // scoreboard pop for every bit the sink accepts on the coming edge
  always @(negedge clk) begin
    logic [2:0] exp;
    if (!rst && ack0) ack0_cnt++;
    if (!rst && ack1) ack1_cnt++;
    if (!rst && sout_en && ser_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $error("FAIL bit_unexpected observed=%0h expected=none", {owner, sout, last});
      end else begin
        exp = q.pop_front();
        assert ({owner, sout, last} === exp) else begin
          bad++;
          $error("FAIL bit observed=%0h expected=%0h", {owner, sout, last}, exp);
        end
      end
    end
  end

  // scoreboard for the zero-gap instance
  always @(negedge clk) begin
    logic [2:0] exp;
    if (!rst && g0_ack0) g0_ack_cnt++;
    if (!rst && g0_sout_en && g0_ready) begin
      total++;
      if (q_g0.size() == 0) begin
        bad++;
        $error("FAIL g0_bit_unexpected observed=%0h expected=none", {g0_owner, g0_sout, g0_last});
      end else begin
        exp = q_g0.pop_front();
        assert ({g0_owner, g0_sout, g0_last} === exp) else begin
          bad++;
          $error("FAIL g0_bit observed=%0h expected=%0h", {g0_owner, g0_sout, g0_last}, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ser_ready = 1'b1;
    data0 = 4'h0; data1 = 4'h0;
    g0_req0 = 1'b0; g0_req1 = 1'b0; g0_ready = 1'b1;
    g0_data0 = 4'h0; g0_data1 = 4'h0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_sout_en", sout_en, 0);
    check("rst_sout", sout, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_last", last, 0);
    check("rst_owner", owner, 0);
    rst = 1'b0;
    tick(1);

    // single req0 frame 1011
    req0 = 1'b1; data0 = 4'b1011;
    push_frame(1'b0, 4'b1011, 1'b0);
    tick(1);
    check("t1_ack0", ack0, 1);
    check("t1_first", {sout_en, sout, owner, busy}, 4'b1101);
    req0 = 1'b0;
    tick(1);
    check("t1_ack0_clr", ack0, 0);
    tick(2);
    check("t1_last", last, 1);
    tick(1);
    check("t1_gap", {sout_en, busy, last}, 3'b010);
    tick(1);
    check("t1_idle", busy, 0);

    // contention after reset: pointer restarts on req0, then alternates
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 4'hA; data1 = 4'h5;
    push_frame(1'b0, 4'hA, 1'b0);
    push_frame(1'b1, 4'h5, 1'b0);
    push_frame(1'b0, 4'hA, 1'b0);
    push_frame(1'b1, 4'h5, 1'b0);
    tick(1);
    check("t2_g0", {ack0, ack1, owner}, 3'b100);
    tick(6);
    check("t2_g1", {ack0, ack1, owner}, 3'b011);
    tick(6);
    check("t2_g2", {ack0, ack1, owner}, 3'b100);
    tick(6);
    check("t2_g3", {ack0, ack1, owner}, 3'b011);
    req0 = 1'b0; req1 = 1'b0;
    tick(6);
    check("t2_idle", busy, 0);
    check("t2_q_empty", q.size(), 0);

    // req1 frame 1100 with a three-cycle stall on the third bit
    req1 = 1'b1; data1 = 4'b1100;
    push_frame(1'b1, 4'b1100, 1'b0);
    tick(1);
    check("t3_ack1", {ack1, owner}, 2'b11);
    req1 = 1'b0;
    tick(2);
    ser_ready = 1'b0;
    tick(1);
    check("t3_stall_a", {sout_en, sout, last}, 3'b100);
    tick(2);
    check("t3_stall_b", {sout_en, sout, last}, 3'b100);
    ser_ready = 1'b1;
    tick(1);
    check("t3_last", {sout_en, sout, last}, 3'b101);
    tick(1);
    check("t3_gap", {sout_en, last}, 2'b00);
    tick(1);
    check("t3_idle", busy, 0);

    // asynchronous reset during the third bit of 0110
    req0 = 1'b1; data0 = 4'b0110;
    push_frame(1'b0, 4'b0110, 1'b0);
    tick(1);
    check("t4_ack0", ack0, 1);
    req0 = 1'b0;
    tick(2);
    check("t4_pre_sout", {sout_en, sout}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("t4_async", {sout, sout_en, ack0, ack1, busy}, 5'b00000);
    check("t4_q_left", q.size(), 2);
    q.delete();
    tick(1);
    rst = 1'b0;
    req1 = 1'b1; data1 = 4'b1001;
    push_frame(1'b1, 4'b1001, 1'b0);
    tick(1);
    check("t4_regrant", {ack1, owner}, 2'b11);
    req1 = 1'b0;
    tick(5);
    check("t4_idle", busy, 0);

    // req1 pulsed during a req0 frame is ignored and leaves the pointer alone
    snap = ack1_cnt;
    req0 = 1'b1; data0 = 4'hC;
    push_frame(1'b0, 4'hC, 1'b0);
    tick(1);
    check("t6_ack0", ack0, 1);
    req0 = 1'b0; req1 = 1'b1; data1 = 4'hF;
    tick(1);
    req1 = 1'b0;
    tick(4);
    check("t6_idle", busy, 0);
    check("t6_no_ack1", ack1_cnt, snap);
    req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'h6;
    push_frame(1'b1, 4'h6, 1'b0);
    push_frame(1'b0, 4'h3, 1'b0);
    tick(1);
    check("t6_ptr", {ack0, ack1, owner}, 3'b011);
    req1 = 1'b0;
    tick(6);
    check("t6_next", {ack0, ack1, owner}, 3'b100);
    req0 = 1'b0;
    tick(6);
    check("t6_done", busy, 0);

    // zero-gap instance: exactly one IDLE cycle between frames
    snap = g0_ack_cnt;
    g0_req0 = 1'b1; g0_data0 = 4'b1001;
    push_frame(1'b0, 4'b1001, 1'b1);
    push_frame(1'b0, 4'b1001, 1'b1);
    push_frame(1'b0, 4'b1001, 1'b1);
    tick(1);
    check("t5_ack_a", g0_ack0, 1);
    tick(4);
    check("t5_idle_gap", {g0_busy, g0_sout_en}, 2'b00);
    tick(1);
    check("t5_ack_b", {g0_ack0, g0_busy}, 2'b11);
    tick(5);
    check("t5_ack_c", g0_ack0, 1);
    g0_req0 = 1'b0;
    tick(5);
    check("t5_idle", g0_busy, 0);
    check("t5_ack_count", g0_ack_cnt - snap, 3);
    check("t5_q_empty", q_g0.size(), 0);

    check("final_q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Round-robin scheduler that shares one W-bit parallel-in/serial-out shift register between two requesters. It sequences each transfer: arbitrate, load the word, shift it out MSB-first under a downstream ready handshake, then insert an inter-frame gap. It sits between two word-producing blocks and a single serial sink.

## Interface
- W, default 4: word width, bits per frame; legal range W >= 2.
- GAP, default 1: idle cycles inserted after each frame; legal range GAP >= 0.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 has a word pending; held high with data0 stable until ack0.
- data0  input  W  requester 0 word.
- req1  input  1  requester 1 has a word pending; held high with data1 stable until ack1.
- data1  input  W  requester 1 word.
- ack0  output  1  one-cycle pulse: data0 captured.
- ack1  output  1  one-cycle pulse: data1 captured.
- sout  output  1  serial data, MSB first; 0 when sout_en is low.
- sout_en  output  1  sout carries a valid bit.
- ser_ready  input  1  sink accepts the bit on the current edge.
- last  output  1  current sout bit is the frame's final bit.
- owner  output  1  requester index of the frame in flight; holds its last value when idle.
- busy  output  1  state is not IDLE.

## Operation
- Reset values:
  - state = IDLE.
  - sr = 0, bit counter = 0, gap counter = 0.
  - Priority pointer favours req0.
  - ack0 = ack1 = 0, sout = 0, sout_en = 0, last = 0, owner = 0, busy = 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - At an edge where any req is high, grant the requester selected by the pointer.
  - If only one req is high, grant it regardless of the pointer.
  - On grant: sr <= data of the winner, owner <= winner, ack of the winner <= 1, bit counter <= W-1, state <= SHIFT.
  - The pointer then favours the other requester.
- SHIFT:
  - sout = sr[W-1], sout_en = 1, last = (bit counter == 0).
  - At an edge with ser_ready = 1: sr <= {sr[W-2:0], 0} and the bit counter decrements.
  - If the bit counter was 0 at that edge: state <= GAP when GAP > 0, else IDLE; the gap counter loads GAP-1.
  - With ser_ready = 0, sr, the bit counter, sout and last hold.
- GAP:
  - sout_en = 0; the gap counter decrements each edge.
  - At the edge where the gap counter is 0, state <= IDLE.
- ack0/ack1 are registered, high exactly one cycle (the first SHIFT cycle), then cleared.
- A requester may drop req before its grant (withdrawal). No ack is issued and the pointer is unaffected.
- Requests are ignored outside IDLE. A req left high past its ack is treated as a new request at the next IDLE.
- Counter widths: bit counter $clog2(W) bits, gap counter $clog2(GAP+1) bits, minimum 1. Counters never wrap below 0.

## Timing
- Grant latency: capture at the first edge in IDLE with a req high. ack and the first bit are both visible in the following cycle.
- Frame length with ser_ready held high: W cycles of sout_en. Capture-to-capture minimum period is W + GAP + 1 edges (one IDLE cycle is always present).
- Each low cycle of ser_ready extends the frame by one cycle.
- Simultaneous req0 and req1 in IDLE: the pointer decides. Back-to-back contention alternates 0, 1, 0, 1.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). No partial-frame ack is repeated after reset, and the pointer returns to favour req0.
- ser_ready is ignored outside SHIFT.

## Test plan
- W=4, GAP=1, reset then req0 with data0=4'b1011, ser_ready=1 → ack0 one cycle after capture; sout=1,0,1,1 over 4 cycles; last on the 4th; sout_en low for 1 gap cycle; busy low afterwards.
- req0 and req1 held high continuously, data0=4'hA, data1=4'h5 → frames alternate owner 0,1,0,1. Serial stream 1010, 0101, … with a capture every 6 edges.
- During a req1 frame (data1=4'b1100), ser_ready low for 3 cycles after the 2nd bit → sout holds 0 while stalled. Frame ends 3 cycles later; bit order is unchanged; last is asserted only on the 4th bit.
- Assert rst during the 3rd bit of a frame → sout, sout_en, ack and busy go 0 immediately. After release, a new req1 with req0 low is granted and owner=1.
- GAP=0, req0 held high with constant data0 → frames separated by exactly one IDLE cycle. Each frame is acked exactly once.
- req1 pulsed for one cycle while a frame is in SHIFT, then withdrawn → no ack1 and no frame for requester 1. The pointer is unchanged.
